// File: rtl/gshare_btb_ras_predictor_if.sv
// Fetch-predict and EX-resolve signal bundle for the gshare/BTB/RAS predictor.
// The pipeline side is the master; the predictor is the slave.
interface gshare_btb_ras_predictor_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned PHT_IDX_W = 5,
    parameter int unsigned GHR_W     = 5
);
    logic                 fetch_valid;
    logic [XLEN-1:0]      fetch_pc;
    logic [XLEN-1:0]      pred_next_pc;
    logic                 pred_taken;
    logic [PHT_IDX_W-1:0] pred_pht_index;
    logic [GHR_W-1:0]     pred_ghr;

    logic                 res_valid;
    logic [1:0]           res_type;
    logic                 res_is_call;
    logic                 res_is_ret;
    logic [XLEN-1:0]      res_pc;
    logic                 res_taken;
    logic [XLEN-1:0]      res_target;
    logic [PHT_IDX_W-1:0] res_pht_index;
    logic [GHR_W-1:0]     res_ghr;
    logic                 res_mispredict;

    modport master (
        output fetch_valid, fetch_pc,
        output res_valid, res_type, res_is_call, res_is_ret, res_pc, res_taken,
               res_target, res_pht_index, res_ghr, res_mispredict,
        input  pred_next_pc, pred_taken, pred_pht_index, pred_ghr
    );

    modport slave (
        input  fetch_valid, fetch_pc,
        input  res_valid, res_type, res_is_call, res_is_ret, res_pc, res_taken,
               res_target, res_pht_index, res_ghr, res_mispredict,
        output pred_next_pc, pred_taken, pred_pht_index, pred_ghr
    );
endinterface

// File: rtl/gshare_btb_ras_predictor.sv
// Fetch-stage next-PC predictor: gshare PHT, tagged typed BTB and a circular RAS.
// Prediction is combinational from fetch_pc; training and GHR repair come from EX.
module gshare_btb_ras_predictor #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned PHT_IDX_W = 5,
    parameter int unsigned GHR_W     = 5,
    parameter int unsigned BTB_IDX_W = 5,
    parameter int unsigned RAS_DEPTH = 4,
    parameter logic [1:0]  PHT_INIT  = 2'b01
) (
    input logic clk,
    input logic reset,
    gshare_btb_ras_predictor_if.slave bus
);
    localparam int unsigned PHT_N     = 2 ** PHT_IDX_W;
    localparam int unsigned BTB_N     = 2 ** BTB_IDX_W;
    localparam int unsigned TAG_W     = XLEN - BTB_IDX_W - 2;
    localparam int unsigned RAS_PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned RAS_CNT_W = RAS_PTR_W + 1;

    typedef enum logic [1:0] {KIND_COND, KIND_JUMP, KIND_CALL, KIND_RET} kind_e;
    typedef enum logic [1:0] {RES_NONE, RES_BRANCH, RES_JAL, RES_JALR} res_type_e;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        kind_e            kind;
    } btb_entry_t;

    logic [GHR_W-1:0]     ghr_q, ghr_d;
    logic [1:0]           pht_q [PHT_N];
    logic [1:0]           pht_d [PHT_N];
    btb_entry_t           btb_q [BTB_N];
    btb_entry_t           btb_d [BTB_N];
    logic [XLEN-1:0]      ras_q [RAS_DEPTH];
    logic [XLEN-1:0]      ras_d [RAS_DEPTH];
    logic [RAS_PTR_W-1:0] ras_ptr_q, ras_ptr_d;
    logic [RAS_CNT_W-1:0] ras_cnt_q, ras_cnt_d;

    // New history bit enters at the MSB; works for any GHR_W >= 1.
    function automatic logic [GHR_W-1:0] shift_in(input logic b, input logic [GHR_W-1:0] g);
        logic [GHR_W:0] t;
        t = {b, g};
        return t[GHR_W:1];
    endfunction

    function automatic logic [1:0] sat_update(input logic [1:0] c, input logic up);
        if (up) return (c == 2'b11) ? c : c + 2'd1;
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    // Fetch-side lookup
    logic [BTB_IDX_W-1:0] f_btb_idx;
    btb_entry_t           f_ent;
    logic                 f_hit;
    logic [PHT_IDX_W-1:0] f_pht_idx;
    logic                 f_taken;
    logic [XLEN-1:0]      f_pc_plus4;
    logic [XLEN-1:0]      f_target;
    logic                 ras_empty;
    logic [RAS_PTR_W-1:0] ras_top_idx;

    assign f_btb_idx   = bus.fetch_pc[BTB_IDX_W+1:2];
    assign f_ent       = btb_q[f_btb_idx];
    assign f_hit       = f_ent.valid && (f_ent.tag == bus.fetch_pc[XLEN-1:BTB_IDX_W+2]);
    assign f_pht_idx   = bus.fetch_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr_q);
    assign f_taken     = f_hit && ((f_ent.kind != KIND_COND) || pht_q[f_pht_idx][1]);
    assign f_pc_plus4  = bus.fetch_pc + XLEN'(4);
    assign ras_empty   = (ras_cnt_q == '0);
    assign ras_top_idx = ras_ptr_q - RAS_PTR_W'(1);
    assign f_target    = (f_ent.kind == KIND_RET && !ras_empty) ? ras_q[ras_top_idx] : f_ent.target;

    assign bus.pred_taken     = f_taken;
    assign bus.pred_next_pc   = f_taken ? f_target : f_pc_plus4;
    assign bus.pred_pht_index = f_pht_idx;
    assign bus.pred_ghr       = ghr_q;

    // Resolve-side decode
    logic [BTB_IDX_W-1:0] r_btb_idx;
    logic                 r_hit;
    logic                 r_act;
    logic                 r_branch;
    logic                 r_jump;
    logic                 r_recover;
    logic                 r_btb_we;
    kind_e                r_kind;
    logic                 unused_res_pc_lsb;

    assign r_btb_idx = bus.res_pc[BTB_IDX_W+1:2];
    assign r_hit     = btb_q[r_btb_idx].valid &&
                       (btb_q[r_btb_idx].tag == bus.res_pc[XLEN-1:BTB_IDX_W+2]);
    assign r_act     = bus.res_valid && (res_type_e'(bus.res_type) != RES_NONE);
    assign r_branch  = res_type_e'(bus.res_type) == RES_BRANCH;
    assign r_jump    = (res_type_e'(bus.res_type) == RES_JAL) ||
                       (res_type_e'(bus.res_type) == RES_JALR);
    assign r_recover = r_act && bus.res_mispredict;
    assign r_btb_we  = r_act && ((bus.res_taken && bus.res_mispredict) || (r_jump && !r_hit));
    assign r_kind    = bus.res_is_ret  ? KIND_RET  :
                       bus.res_is_call ? KIND_CALL :
                       r_jump          ? KIND_JUMP : KIND_COND;
    assign unused_res_pc_lsb = ^bus.res_pc[1:0];

    always_comb begin
        ghr_d     = ghr_q;
        pht_d     = pht_q;
        btb_d     = btb_q;
        ras_d     = ras_q;
        ras_ptr_d = ras_ptr_q;
        ras_cnt_d = ras_cnt_q;

        // Speculative history and RAS, suppressed while EX is redirecting
        if (bus.fetch_valid && !r_recover && f_hit) begin
            if (f_ent.kind == KIND_COND) begin
                ghr_d = shift_in(f_taken, ghr_q);
            end
            if (f_ent.kind == KIND_CALL && f_taken) begin
                ras_d[ras_ptr_q] = f_pc_plus4;
                ras_ptr_d        = ras_ptr_q + RAS_PTR_W'(1);
                if (ras_cnt_q != RAS_CNT_W'(RAS_DEPTH)) begin
                    ras_cnt_d = ras_cnt_q + RAS_CNT_W'(1);
                end
            end
            if (f_ent.kind == KIND_RET && f_taken && !ras_empty) begin
                ras_ptr_d = ras_top_idx;
                ras_cnt_d = ras_cnt_q - RAS_CNT_W'(1);
            end
        end

        if (r_recover) begin
            ghr_d = r_branch ? shift_in(bus.res_taken, bus.res_ghr) : bus.res_ghr;
        end

        if (r_act && r_branch) begin
            pht_d[bus.res_pht_index] = sat_update(pht_q[bus.res_pht_index], bus.res_taken);
        end

        if (r_btb_we) begin
            btb_d[r_btb_idx].valid  = 1'b1;
            btb_d[r_btb_idx].tag    = bus.res_pc[XLEN-1:BTB_IDX_W+2];
            btb_d[r_btb_idx].target = bus.res_target;
            btb_d[r_btb_idx].kind   = r_kind;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr_q     <= '0;
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
            for (int i = 0; i < int'(PHT_N); i++) pht_q[i] <= PHT_INIT;
            for (int i = 0; i < int'(BTB_N); i++) btb_q[i] <= '0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) ras_q[i] <= '0;
        end else begin
            ghr_q     <= ghr_d;
            pht_q     <= pht_d;
            btb_q     <= btb_d;
            ras_q     <= ras_d;
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
        end
    end
endmodule
